// File: rtl/lab4_alu_sched.sv
// lab4_alu_sched: two-requester round-robin scheduler feeding a small 5-bit ALU (add/sub/shift-add mul).
// Latency: accept edge to rsp_valid is 1 clock for add/sub/reserved, 3 clocks for mul (one B bit per clock).
// Backpressure: one operation in flight; the response holds until rsp_ready, then one IDLE cycle before the next accept.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b    requester N operation handshake (N = 0, 1)
//   rsp_valid/ready/id/data    response handshake, owner id and 8-bit result
//   rsp_carry, rsp_err         add carry / sub no-borrow flag; reserved-opcode flag
//   op_count                   completed responses (saturating); live only when LAB4_SCHED_STATS_EN is defined
module lab4_alu_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [1:0]  req0_op,
    input  logic [1:0]  req1_op,
    input  logic [4:0]  req0_a,
    input  logic [4:0]  req1_a,
    input  logic [4:0]  req0_b,
    input  logic [4:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_carry,
    output logic        rsp_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t      state_q, state_d;
    logic        last_q, last_d;     // requester granted most recently
    logic        id_q, id_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic [1:0]  step_q, step_d;     // mul bit index
    logic [7:0]  res_q, res_d;       // also the mul accumulator
    logic        carry_q, carry_d;
    logic        err_q, err_d;

    logic [5:0]  sum;
    logic [4:0]  diff;
    logic [7:0]  partial;

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = a_q - b_q;
    assign partial = {3'b000, a_q} << step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;  // requester 0 wins the first contention
            id_q    <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= 5'd0;
            b_q     <= 5'd0;
            step_q  <= 2'd0;
            res_q   <= 8'd0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        step_d     = step_q;
        res_d      = res_q;
        carry_d    = carry_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // Under contention the requester not granted last goes first.
                req0_ready = req0_valid & (~req1_valid | last_q);
                req1_ready = req1_valid & (~req0_valid | ~last_q);
                if (req0_ready || req1_ready) begin
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    op_d    = req1_ready ? req1_op : req0_op;
                    a_d     = req1_ready ? req1_a  : req0_a;
                    b_d     = req1_ready ? req1_b  : req0_b;
                    step_d  = 2'd0;
                    res_d   = 8'd0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        res_d   = {3'b000, sum[4:0]};
                        carry_d = sum[5];
                        state_d = RESP;
                    end
                    OP_SUB: begin
                        res_d   = {3'b000, diff};
                        carry_d = (a_q >= b_q);
                        state_d = RESP;
                    end
                    OP_MUL: begin
                        if (b_q[step_q]) begin
                            res_d = res_q + partial;
                        end
                        step_d = step_q + 2'd1;
                        if (step_q == 2'd2) begin
                            state_d = RESP;
                        end
                    end
                    default: begin
                        res_d   = 8'd0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fields read as zero whenever no response is presented.
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_data  = rsp_valid ? res_q : 8'd0;
    assign rsp_carry = rsp_valid & carry_q;
    assign rsp_err   = rsp_valid & err_q;

`ifdef LAB4_SCHED_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_valid && rsp_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`else
    assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_lab4_alu_sched.sv
// Bench for lab4_alu_sched: directed literal cases plus randomized traffic,
// with a transaction-level model checking every output on every falling edge.
module tb_lab4_alu_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [4:0]  req0_a, req1_a, req0_b, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [7:0]  rsp_data;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    lab4_alu_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req1_a     (req1_a),
        .req0_b     (req0_b),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference ALU behaviour from the operation definitions.
    function automatic logic [9:0] alu_ref(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
        int r;
        logic [7:0] d;
        logic c, e;
        d = 8'd0; c = 1'b0; e = 1'b0;
        case (op)
            2'b00: begin r = a + b; d = 8'(r % 32); c = (r >= 32); end
            2'b01: begin r = (a - b + 32) % 32; d = 8'(r); c = (a >= b); end
            2'b10: begin r = a * (b % 8); d = 8'(r); end
            default: e = 1'b1;
        endcase
        return {e, c, d};
    endfunction

    // Transaction model: idle / busy-with-countdown / presenting response.
    int          m_phase;  // 0 idle, 1 computing, 2 response presented
    int          m_left;
    bit          m_last;
    bit          m_id;
    logic [9:0]  m_res;
    int          m_cnt;

    function automatic logic [15:0] exp_count();
`ifdef LAB4_SCHED_STATS_EN
        return 16'(m_cnt);
`else
        return 16'd0;
`endif
    endfunction

    initial begin : model
        bit e0, e1;
        bit ev;
        m_phase = 0; m_left = 0; m_last = 1'b1; m_id = 1'b0; m_res = '0; m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_last = 1'b1; m_cnt = 0;
                check("m_rst_valid", 32'(rsp_valid), 0);
                check("m_rst_data", 32'(rsp_data), 0);
                check("m_rst_count", 32'(op_count), 0);
            end else begin
                ev = (m_phase == 2);
                e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
                e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
                check("m_ready0", 32'(req0_ready), 32'(e0));
                check("m_ready1", 32'(req1_ready), 32'(e1));
                check("m_valid", 32'(rsp_valid), 32'(ev));
                check("m_id", 32'(rsp_id), ev ? 32'(m_id) : 0);
                check("m_data", 32'(rsp_data), ev ? 32'(m_res[7:0]) : 0);
                check("m_carry", 32'(rsp_carry), ev ? 32'(m_res[8]) : 0);
                check("m_err", 32'(rsp_err), ev ? 32'(m_res[9]) : 0);
                check("m_count", 32'(op_count), 32'(exp_count()));
                // Advance to the state after the coming rising edge.
                if (m_phase == 0) begin
                    if (e0 || e1) begin
                        m_id   = e1;
                        m_last = e1;
                        m_res  = e1 ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
                        m_left = ((e1 ? req1_op : req0_op) == 2'b10) ? 3 : 1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end else begin
                    if (rsp_ready) begin
                        m_phase = 0;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
        end
    end

    // Present one operation on requester id alone; report clocks from accept to rsp_valid.
    task automatic issue(input bit id, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         output int lat);
        int w;
        @(posedge clk); #1;
        req0_valid = !id; req1_valid = id;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_op = op; req0_a = a; req0_b = b; end
        w = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_bound", 32'(w < 20), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin : main
        int lat;
        int seen;
        int w;
        int ids[4];
        logic [7:0] hold_data;
        bit hold_id, hold_carry, stable, no_acc, any_valid;
        bit rst_pend;

        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 0);
        check("reset_data", 32'(rsp_data), 0);
        check("reset_count", 32'(op_count), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        rsp_ready = 1'b1;

        issue(1'b0, 2'b00, 5'd23, 5'd14, lat);
        check("add_lat", 32'(lat), 1);
        check("add_id", 32'(rsp_id), 0);
        check("add_data", 32'(rsp_data), 32'h05);
        check("add_carry", 32'(rsp_carry), 1);
        check("add_err", 32'(rsp_err), 0);

        issue(1'b1, 2'b01, 5'd3, 5'd5, lat);
        check("sub_id", 32'(rsp_id), 1);
        check("sub_data", 32'(rsp_data), 32'h1E);
        check("sub_carry", 32'(rsp_carry), 0);
        issue(1'b1, 2'b01, 5'd9, 5'd9, lat);
        check("sub_eq_data", 32'(rsp_data), 32'h00);
        check("sub_eq_carry", 32'(rsp_carry), 1);

        issue(1'b0, 2'b10, 5'd31, 5'd7, lat);
        check("mul_lat", 32'(lat), 3);
        check("mul_data", 32'(rsp_data), 32'hD9);
        check("mul_carry", 32'(rsp_carry), 0);

        // Contention after reset: strict alternation starting with requester 0.
        pulse_reset();
        req0_op = 2'b00; req0_a = 5'd1; req0_b = 5'd1;
        req1_op = 2'b00; req1_a = 5'd2; req1_b = 5'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        seen = 0; w = 0;
        while (seen < 4 && w < 60) begin
            @(negedge clk);
            w++;
            if (rsp_valid && rsp_ready) begin
                ids[seen] = int'(rsp_id);
                seen++;
            end
        end
        check("rr_count", 32'(seen), 4);
        check("rr_g0", 32'(ids[0]), 0);
        check("rr_g1", 32'(ids[1]), 1);
        check("rr_g2", 32'(ids[2]), 0);
        check("rr_g3", 32'(ids[3]), 1);
        @(posedge clk); #1; rsp_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
        check("hold_valid", 32'(rsp_valid), 1);
        hold_data = rsp_data; hold_id = rsp_id; hold_carry = rsp_carry;
        check("hold_id", 32'(hold_id), 0);
        check("hold_data", 32'(hold_data), 32'h02);
        stable = 1'b1; no_acc = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== hold_data || rsp_id !== hold_id || rsp_carry !== hold_carry)
                stable = 1'b0;
            if (req0_ready || req1_ready) no_acc = 1'b0;
        end
        check("hold_stable", 32'(stable), 1);
        check("hold_no_accept", 32'(no_acc), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset in the middle of a mul: the operation vanishes.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 5'd13; req0_b = 5'd5;
        @(negedge clk);
        check("abort_accept", 32'(req0_ready), 1);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) any_valid = 1'b1;
        end
        check("abort_no_rsp", 32'(any_valid), 0);
        issue(1'b0, 2'b11, 5'd17, 5'd4, lat);
        check("rsv_lat", 32'(lat), 1);
        check("rsv_err", 32'(rsp_err), 1);
        check("rsv_data", 32'(rsp_data), 0);
        check("rsv_carry", 32'(rsp_carry), 0);
        @(posedge clk);
        @(negedge clk);
`ifdef LAB4_SCHED_STATS_EN
        check("count_after_abort", 32'(op_count), 1);
`else
        check("count_after_abort", 32'(op_count), 0);
`endif

        // Randomized traffic with occasional resets; the model checks every cycle.
        rst_pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (rst_pend) begin
                rst_n = 1'b1;
                rst_pend = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                rst_pend = 1'b1;
            end
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = 2'($urandom_range(0, 3));
            req1_op = 2'($urandom_range(0, 3));
            req0_a = 5'($urandom); req0_b = 5'($urandom);
            req1_a = 5'($urandom); req1_b = 5'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("final_idle", 32'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lab4_alu_sched.md
LAB4_ALU_SCHED -- requirements
Module: lab4_alu_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_op, req1_op  input  2 each  operation: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-007 req0_a, req1_a  input  5 each  operand A, unsigned.
REQ-008 req0_b, req1_b  input  5 each  operand B, unsigned; mul uses only bits [2:0].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  8  result value.
REQ-013 rsp_carry  output  1  add carry-out, or sub no-borrow flag.
REQ-014 rsp_err  output  1  reserved opcode was issued.
REQ-015 op_count  output  16  number of completed responses (see Configuration).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 In IDLE with one valid requester, that requester SHALL receive ready=1 in the same cycle, combinationally.
REQ-018 In IDLE with both requesters valid, the requester not granted last SHALL receive ready; the other ready SHALL be 0.
REQ-019 Outside IDLE, both ready outputs SHALL be 0.
REQ-020 An accept (valid&ready at a rising edge) SHALL capture id, op, A, B, update the last-grant pointer and enter EXEC.
REQ-021 Add: rsp_data = {3'b0, (A+B)[4:0]}; rsp_carry = (A+B)[5].
REQ-022 Sub: rsp_data = {3'b0, (A-B) mod 32}; rsp_carry = 1 iff A >= B.
REQ-023 Mul: rsp_data = A * B[2:0] (full 8 bits), computed by shift-add over 3 EXEC cycles (one B bit per cycle, LSB first); rsp_carry = 0.
REQ-024 Op 11: rsp_data = 0, rsp_carry = 0, rsp_err = 1; rsp_err SHALL be 0 for all other ops.
REQ-025 EXEC SHALL last 1 cycle for add, sub and op 11, and 3 cycles for mul, then enter RESP.
REQ-026 Resulting latency from accept edge to rsp_valid high: 1 clock for add/sub/op 11, 3 clocks for mul.
REQ-027 In RESP, rsp_valid=1 and rsp_id/data/carry/err SHALL hold stable until rsp_ready=1 at a rising edge, then return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the cycle rsp completes; earliest accept is the following IDLE cycle.
REQ-029 Requester inputs changing during EXEC/RESP SHALL have no effect on the in-flight result.
REQ-030 With rsp_valid=0, rsp_data/carry/err/id SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE; rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err = 0; op_count = 0.
REQ-032 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-033 A reset during EXEC or RESP SHALL discard the in-flight operation, with no response produced.

Configuration
REQ-034 With LAB4_SCHED_STATS_EN defined, op_count SHALL increment on each response handshake (rsp_valid&rsp_ready) and saturate at 16'hFFFF.
REQ-035 Without LAB4_SCHED_STATS_EN, op_count SHALL be constant 0 with no counter logic; all other behaviour is identical.

Verification
REQ-036 Req0 add A=23 B=14, rsp_ready=1 -> 1 clock later: rsp_valid, id=0, data=0x05, carry=1.
REQ-037 Req1 sub A=3 B=5 -> data=0x1E, carry=0; then A=9 B=9 -> data=0x00, carry=1.
REQ-038 Req0 mul A=31 B=7 -> rsp_valid exactly 3 clocks after accept, data=0xD9 (217), carry=0.
REQ-039 Both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1; rsp_ready held 0 for 5 cycles -> outputs stable and no accepts.
REQ-040 Mul accepted, rst_n pulsed low mid-EXEC -> no rsp_valid; op 11 then yields err=1, data=0; with LAB4_SCHED_STATS_EN op_count counts only completed responses, else reads 0.
